shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//   Round-robin arbiter and write sequencer for one shared WIDTH-bit register
//   built from D_FF cells. NREQ requesters compete for write access.
//   The block grants one requester at a time and loads that requester's data
//   into the register. It reports write completion and keeps a running write count.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  8   width of the shared register and of each requester's data
// PORTS
//   clk      in   1           rising-edge clock
//   reset    in   1           asynchronous, active-low reset
//   req      in   NREQ        write request, one bit per requester
//   wdata    in   NREQ*WIDTH  requester i data on wdata[i*WIDTH +: WIDTH]
//   gnt      out  NREQ        one-hot grant, registered
//   q        out  WIDTH       shared register contents
//   q_valid  out  1           1-cycle pulse after q is updated
//   busy     out  1           1 whenever state != IDLE
//   wr_cnt   out  16          count of completed writes, wraps at 16'hFFFF->0
// BEHAVIOUR
//   - Reset (reset=0), applied asynchronously:
//     - state=IDLE, gnt=0, q=0, q_valid=0, busy=0, wr_cnt=0.
//     - ptr=NREQ-1, so requester 0 has first priority.
//   - FSM states: IDLE -> GRANT -> RELEASE -> IDLE, one clock per state.
//   - IDLE:
//     - If req!=0, pick winner W: the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
//     - At the edge: gnt<=onehot(W), state<=GRANT.
//     - If req==0, stay in IDLE and hold gnt=0.
//   - GRANT (gnt[W]=1 for exactly this cycle):
//     - Requester W must hold req[W] and wdata stable during this cycle.
//     - At the edge, if req[W]=1: q<=wdata[W], q_valid<=1, wr_cnt<=wr_cnt+1, ptr<=W.
//     - At the edge, if req[W]=0 (abort): q, wr_cnt and ptr are unchanged, and q_valid stays 0.
//     - Either way: gnt<=0, state<=RELEASE.
//   - RELEASE:
//     - Dead cycle. req is ignored so requesters can drop req after seeing gnt.
//     - q_valid is 1 here only when the GRANT cycle completed a write.
//     - At the edge: q_valid<=0, state<=IDLE.
//   - Latency: req sampled in IDLE -> gnt high 1 cycle later -> q updated 2 edges after the sample.
//   - Throughput: at most one write per 3 cycles.
//   - Fairness: a requester holding req high is served within NREQ transactions.
//   - Request changes during GRANT and RELEASE do not affect the current transaction.
//   - Only the granted requester's wdata is ever loaded into q.
//   - gnt is never multi-hot; gnt!=0 only in GRANT; busy=(state!=IDLE).
//   - Reset asserted mid-transaction:
//     - All outputs clear at once without waiting for clk.
//     - After reset release, arbitration restarts from requester 0.
// TESTING  (NREQ=4, WIDTH=8)
//   1. Assert reset=0 mid-run
//      -> q=8'h00, gnt=4'b0000, q_valid=0, busy=0, wr_cnt=0 before the next clk edge.
//   2. After reset, pulse req=4'b0100 with wdata[2]=8'hA5, dropping req on gnt
//      -> gnt=4'b0100 for 1 cycle, q=8'hA5 and q_valid=1 the next cycle, wr_cnt=1.
//   3. Hold req=4'b1111 with data 8'h10,11,12,13
//      -> grants 0,1,2,3,0 spaced 3 cycles apart, q sequence 10,11,12,13,10.
//   4. req[1] granted, then req[1] dropped during GRANT
//      -> q holds its old value, q_valid=0, wr_cnt unchanged.
//      -> next request set {1,3} is granted to 1 (ptr not advanced).
//   5. Last write by requester 3, then req=4'b1001 simultaneously
//      -> gnt=4'b0001 (wrap-around to 0), followed by gnt=4'b1000.
//   6. Preload wr_cnt to 16'hFFFF via 65535 writes (or force), then one more write
//      -> wr_cnt=16'h0000.
//   7. Assert reset during GRANT of requester 2, then release it with req=4'b1111
//      -> gnt drops at once, q=0; the first grant after release is 4'b0001.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter and write sequencer for one shared register
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic                  busy,
    output logic [15:0]           wr_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    logic [PW-1:0]     win_d;
    logic              found_d;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  q_q;
    logic              q_valid_q;
    logic [15:0]       wr_cnt_q;

    // Search starts just after the last successful writer, wrapping modulo NREQ.
    always_comb begin
        win_d   = ptr_q;
        found_d = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_d && req[(int'(ptr_q) + k) % NREQ]) begin
                win_d   = PW'((int'(ptr_q) + k) % NREQ);
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(NREQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    q_valid_q <= 1'b0;
                    if (found_d) begin
                        win_q   <= win_d;
                        gnt_q   <= NREQ'(1) << win_d;
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    gnt_q   <= '0;
                    state_q <= RELEASE;
                    // A requester that dropped req during its grant aborts: nothing moves.
                    if (req[win_q]) begin
                        q_q       <= wdata[int'(win_q)*WIDTH +: WIDTH];
                        q_valid_q <= 1'b1;
                        wr_cnt_q  <= wr_cnt_q + 16'd1;
                        ptr_q     <= win_q;
                    end
                end
                RELEASE: begin
                    q_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    gnt_q     <= '0;
                    q_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q != IDLE);
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter with a transaction-level model
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic        busy;
    logic [15:0] wr_cnt;

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .q_valid(q_valid), .busy(busy), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] c;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  gq[$];
    wr_t         wq[$];
    int          m_phase;
    int          m_ptr;
    int          m_w;
    logic [15:0] m_cnt;
    logic [7:0]  exp_q;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 3;
        m_cnt   = 16'h0;
        exp_q   = 8'h00;
        gq.delete();
        wq.delete();
    endtask

    // Transaction model: phase 0 idle, 1 grant, 2 release; state after the coming edge.
    task automatic step();
        bit found;
        case (m_phase)
            0: if (req != 4'b0000) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        m_w   = (m_ptr + k) % 4;
                        found = 1;
                    end
                end
                gq.push_back(4'(1 << m_w));
                m_phase = 1;
            end
            1: begin
                if (req[m_w]) begin
                    m_cnt = m_cnt + 16'd1;
                    m_ptr = m_w;
                    wq.push_back('{wdata[m_w*8 +: 8], m_cnt});
                end
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic cyc(input logic [3:0] r, input logic [31:0] d);
        @(negedge clk);
        req   = r;
        wdata = d;
        step();
    endtask

    task automatic do_reset(input logic [3:0] r_after);
        reset = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = r_after;
        wdata = $urandom;
        step();
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chk("busy", busy, (m_phase != 0));
                chk("gnt_onehot", ($countones(gnt) <= 1), 1);
                if (gnt != 4'b0000) begin
                    if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
                    else chk("gnt", gnt, gq.pop_front());
                end
                if (q_valid) begin
                    if (wq.size() == 0) chk("q_valid_unexpected", q_valid, 0);
                    else begin
                        e = wq.pop_front();
                        chk("q", q, e.d);
                        chk("wr_cnt", wr_cnt, e.c);
                        exp_q = e.d;
                    end
                end
                chk("q_hold", q, exp_q);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_gnt", gnt, 0);
        chk("init_q", q, 0);
        chk("init_busy", busy, 0);
        chk("init_wr_cnt", wr_cnt, 0);
        reset = 1'b1;

        // single pulse from requester 2, dropped after its grant
        cyc(4'b0100, 32'h00A5_0000);
        cyc(4'b0100, 32'h00A5_0000);
        cyc(4'b0000, 32'h0);
        cyc(4'b0000, 32'h0);
        chk("t2_q", q, 8'hA5);
        chk("t2_wr_cnt", wr_cnt, 1);

        for (int i = 0; i < 7; i++) cyc(4'($urandom), $urandom);
        #2;
        do_reset(4'b0000);

        // all requesting: strict rotation 0,1,2,3,0
        for (int i = 0; i < 15; i++) cyc(4'b1111, 32'h1312_1110);
        cyc(4'b0000, 32'h0);
        chk("t3_q", q, 8'h10);
        chk("t3_wr_cnt", wr_cnt, 5);

        // wrap-around: last writer 3, then {0,3}
        for (int i = 0; i < 3; i++) cyc(4'b1000, 32'h3300_0000);
        for (int i = 0; i < 6; i++) cyc(4'b1001, 32'h4400_0044);
        cyc(4'b0000, 32'h0);

        // abort by requester 1, then {1,3} must still go to 1
        cyc(4'b0010, 32'h0000_7700);
        cyc(4'b0000, 32'h0000_7700);
        cyc(4'b0000, 32'h0);
        chk("t4_q_held", q, 8'h44);
        chk("t4_wr_cnt_held", wr_cnt, 8);
        for (int i = 0; i < 3; i++) cyc(4'b1010, 32'h5500_6600);
        cyc(4'b0000, 32'h0);
        chk("t4_q_after", q, 8'h66);

        // counter wrap
        for (int i = 0; i < 3; i++) cyc(4'b0000, 32'h0);
        force dut.wr_cnt_q = 16'hFFFE;
        #1;
        release dut.wr_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 6; i++) cyc(4'b0001, 32'h0000_00C3);
        cyc(4'b0000, 32'h0);
        chk("t6_wr_cnt_wrap", wr_cnt, 16'h0000);

        for (int i = 0; i < 300; i++) cyc(4'($urandom & $urandom_range(15, 0)), $urandom);

        // reset landing in the grant cycle of requester 2
        for (int i = 0; i < 3; i++) cyc(4'b0000, 32'h0);
        cyc(4'b0100, 32'h00EE_0000);
        @(posedge clk);
        #3;
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) cyc(4'b1111, 32'h0403_0201);

        for (int i = 0; i < 4; i++) cyc(4'b0000, 32'h0);
        chk("drain_gnt_queue", gq.size(), 0);
        chk("drain_write_queue", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
